// File: rtl/muldiv_hilo_pkg.sv
// Shared operation codes, FSM state encoding and helpers for the HI/LO multiply/divide unit.
package muldiv_hilo_pkg;

   localparam logic [4:0] OP_MUL  = 5'h10;
   localparam logic [4:0] OP_MULU = 5'h11;
   localparam logic [4:0] OP_DIV  = 5'h12;
   localparam logic [4:0] OP_DIVU = 5'h13;

   localparam int MD_CNT_W = 5;

   typedef enum logic [1:0] {
      MD_IDLE   = 2'd0,
      MD_ITER   = 2'd1,
      MD_FINISH = 2'd2
   } md_state_e;

   // Magnitude of a 32-bit operand; 0x80000000 maps to itself, read as unsigned.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_hilo_if.sv
// Request/result bundle between the EX stage (master) and the multiply/divide unit (slave).
interface muldiv_hilo_if;
   logic        start;
   logic [4:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, A, B, mthi, mtlo, wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, A, B, mthi, mtlo, wdata,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on a {remainder, quotient} pair.
module div_step (
   input  logic [31:0] i_rem,
   input  logic [31:0] i_quot,
   input  logic [31:0] i_div,
   output logic [31:0] o_rem,
   output logic [31:0] o_quot
);
   logic [32:0] w_shift;
   logic [31:0] w_diff;
   logic        w_ge;

   // Shifted partial remainder needs 33 bits because the remainder may reach divisor-1.
   assign w_shift = {i_rem, i_quot[31]};
   assign w_ge    = (w_shift >= {1'b0, i_div});
   assign w_diff  = w_shift[31:0] - i_div;
   assign o_rem   = w_ge ? w_diff : w_shift[31:0];
   assign o_quot  = {i_quot[30:0], w_ge};
endmodule

// File: rtl/muldiv_hilo.sv
// Multi-cycle MUL/MULU/DIV/DIVU unit holding architectural HI/LO with MTHI/MTLO writes.
// Build option MULDIV_FAST_MUL_EN: single-cycle multiplier at accept instead of shift-add iteration.
module muldiv_hilo
   import muldiv_hilo_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   muldiv_hilo_if.slave  bus
);
   md_state_e             r_state, w_state_next;
   logic [MD_CNT_W-1:0]   r_cnt;
   logic [63:0]           r_work;
   logic [31:0]           r_b;
   logic                  r_is_div, r_neg_q, r_neg_r, r_dbz;
   logic [31:0]           r_hi, r_lo;
   logic                  r_done, r_div_by_zero;

   logic        w_busy, w_is_mul, w_is_div, w_signed, w_accept, w_b_zero, w_fast_mul, w_skip_iter;
   logic [31:0] w_a_mag, w_b_mag, w_step_rem, w_step_quot, w_fin_quot, w_fin_rem;
   logic [32:0] w_mul_sum;
   logic [63:0] w_fast_prod, w_iter_next, w_fin_prod;

   assign w_busy   = (r_state != MD_IDLE);
   assign w_is_mul = (bus.op == OP_MUL) || (bus.op == OP_MULU);
   assign w_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
   assign w_signed = (bus.op == OP_MUL) || (bus.op == OP_DIV);
   assign w_accept = bus.start && !w_busy && (w_is_mul || w_is_div);
   assign w_b_zero = (bus.B == 32'd0);
   assign w_a_mag  = abs32(bus.A, w_signed);
   assign w_b_mag  = abs32(bus.B, w_signed);

`ifdef MULDIV_FAST_MUL_EN
   assign w_fast_mul  = 1'b1;
   assign w_fast_prod = {32'd0, w_a_mag} * {32'd0, w_b_mag};
`else
   assign w_fast_mul  = 1'b0;
   assign w_fast_prod = 64'd0;
`endif

   assign w_skip_iter = (w_is_div && w_b_zero) || (w_is_mul && w_fast_mul);

   div_step u_div_step (
      .i_rem  (r_work[63:32]),
      .i_quot (r_work[31:0]),
      .i_div  (r_b),
      .o_rem  (w_step_rem),
      .o_quot (w_step_quot)
   );

   // Shift-add multiply: work = {partial product, remaining multiplier bits}.
   assign w_mul_sum   = {1'b0, r_work[63:32]} + (r_work[0] ? {1'b0, r_b} : 33'd0);
   assign w_iter_next = r_is_div ? {w_step_rem, w_step_quot} : {w_mul_sum, r_work[31:1]};

   assign w_fin_prod = r_neg_q ? (~r_work + 64'd1) : r_work;
   assign w_fin_quot = r_neg_q ? (~r_work[31:0] + 32'd1) : r_work[31:0];
   assign w_fin_rem  = r_neg_r ? (~r_work[63:32] + 32'd1) : r_work[63:32];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= MD_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         MD_IDLE:   if (w_accept) w_state_next = w_skip_iter ? MD_FINISH : MD_ITER;
         MD_ITER:   if (r_cnt == '0) w_state_next = MD_FINISH;
         MD_FINISH: w_state_next = MD_IDLE;
         default:   w_state_next = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt         <= '0;
         r_work        <= 64'd0;
         r_b           <= 32'd0;
         r_is_div      <= 1'b0;
         r_neg_q       <= 1'b0;
         r_neg_r       <= 1'b0;
         r_dbz         <= 1'b0;
         r_hi          <= 32'd0;
         r_lo          <= 32'd0;
         r_done        <= 1'b0;
         r_div_by_zero <= 1'b0;
      end else begin
         r_done        <= 1'b0;
         r_div_by_zero <= 1'b0;
         case (r_state)
            MD_IDLE: begin
               if (w_accept) begin
                  r_cnt    <= MD_CNT_W'(DIV_CYCLES - 1);
                  r_b      <= w_b_mag;
                  r_is_div <= w_is_div;
                  r_dbz    <= w_is_div && w_b_zero;
                  r_neg_q  <= w_signed && (bus.A[31] ^ bus.B[31]);
                  r_neg_r  <= w_signed && bus.A[31];
                  r_work   <= (w_is_mul && w_fast_mul) ? w_fast_prod : {32'd0, w_a_mag};
               end else begin
                  if (bus.mthi) r_hi <= bus.wdata;
                  if (bus.mtlo) r_lo <= bus.wdata;
               end
            end
            MD_ITER: begin
               r_work <= w_iter_next;
               r_cnt  <= r_cnt - 1'b1;
            end
            MD_FINISH: begin
               r_done        <= 1'b1;
               r_div_by_zero <= r_dbz;
               if (r_dbz) begin
                  r_hi <= 32'd0;
                  r_lo <= 32'd0;
               end else if (r_is_div) begin
                  r_hi <= w_fin_rem;
                  r_lo <= w_fin_quot;
               end else begin
                  r_hi <= w_fin_prod[63:32];
                  r_lo <= w_fin_prod[31:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = w_busy;
   assign bus.done        = r_done;
   assign bus.div_by_zero = r_div_by_zero;
   assign bus.hi          = r_hi;
   assign bus.lo          = r_lo;
endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: directed cases, hazards, mid-op reset and randomized operations.
module tb_muldiv_hilo;
   import muldiv_hilo_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 34;
`endif
   localparam int DIV_LAT = 34;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          acc;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_txn = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   exp_t        sb[$];
   logic [4:0]  valid_ops [4] = '{OP_MUL, OP_MULU, OP_DIV, OP_DIVU};

   muldiv_hilo_if bus();

   muldiv_hilo #(.DIV_CYCLES(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: plain 64-bit arithmetic on the architectural definition.
   function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l,
                                     output logic d, output int lat);
      longint      sa, sbv, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sbv = longint'($signed(b));
      h = 32'd0; l = 32'd0; d = 1'b0; lat = DIV_LAT; q = 0; r = 0; p = 64'd0;
      if (op == OP_MUL) begin
         p = 64'(sa * sbv); h = p[63:32]; l = p[31:0]; lat = MUL_LAT;
      end else if (op == OP_MULU) begin
         p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; lat = MUL_LAT;
      end else if (b == 32'd0) begin
         d = 1'b1; lat = 2;
      end else if (op == OP_DIV) begin
         q = sa / sbv; r = sa % sbv; l = q[31:0]; h = r[31:0];
      end else begin
         q = longint'({32'd0, a}) / longint'({32'd0, b});
         r = longint'({32'd0, a}) % longint'({32'd0, b});
         l = q[31:0]; h = r[31:0];
      end
   endfunction

   // Monitor: pops the scoreboard whenever the DUT reports done.
   always @(negedge clk) begin
      if (reset_n && bus.done) begin
         if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_done: actual=done required=no_done");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result_hi", 64'(bus.hi), 64'(e.hi));
            check("result_lo", 64'(bus.lo), 64'(e.lo));
            check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
            check("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            check("busy_at_done", 64'(bus.busy), 64'd0);
            n_txn++;
            $display("txn %0d: hi=%h lo=%h dbz=%0b latency=%0d", n_txn, bus.hi, bus.lo,
                     bus.div_by_zero, cyc - e.acc + 1);
         end
      end
      if (reset_n && bus.div_by_zero && !bus.done) begin
         n_checks++; n_fail++;
         $display("FAIL dbz_without_done: actual=dbz_alone required=dbz_with_done");
      end
   end

   // Issues one operation from an idle negedge and returns at the done negedge.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed,
                         input int elat, input logic mt_clash);
      exp_t e;
      int   busy_cnt;
      logic stable, got;
      e.hi = eh; e.lo = el; e.dbz = ed; e.acc = cyc + 1; e.lat = elat;
      bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
      bus.mthi = mt_clash; bus.mtlo = mt_clash; bus.wdata = $urandom;
      sb.push_back(e);
      @(posedge clk); #1;
      bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
      bus.A = $urandom; bus.B = $urandom; bus.op = 5'($urandom);
      stable = (bus.hi === m_hi) && (bus.lo === m_lo);
      busy_cnt = 0; got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!bus.busy) begin got = 1'b1; break; end
         busy_cnt++;
         if (bus.hi !== m_hi || bus.lo !== m_lo) stable = 1'b0;
         bus.start = 1'($urandom); bus.op = valid_ops[$urandom_range(0, 3)];
         bus.mthi = 1'($urandom); bus.mtlo = 1'($urandom); bus.wdata = $urandom;
         bus.A = $urandom; bus.B = $urandom;
      end
      bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
      check("done_within_bound", 64'(got), 64'd1);
      check("busy_cycles", 64'(busy_cnt), 64'(elat - 1));
      check("hilo_held_while_busy", 64'(stable), 64'd1);
      m_hi = eh; m_lo = el;
   endtask

   task automatic rand_op();
      logic [4:0]  op;
      logic [31:0] a, b, eh, el;
      logic        ed;
      int          lat;
      op = valid_ops[$urandom_range(0, 3)];
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
         0: b = 32'd0;
         1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         2: begin a = $urandom_range(0, 100); b = $urandom_range(1, 9); end
         3: b = $urandom_range(0, 15);
         default: ;
      endcase
      ref_model(op, a, b, eh, el, ed, lat);
      run_op(op, a, b, eh, el, ed, lat, 1'($urandom));
   endtask

   task automatic mt_write(input logic hi_en, input logic lo_en, input logic [31:0] data);
      bus.mthi = hi_en; bus.mtlo = lo_en; bus.wdata = data; bus.start = 1'b0;
      @(posedge clk); #1;
      bus.mthi = 1'b0; bus.mtlo = 1'b0;
      if (hi_en) m_hi = data;
      if (lo_en) m_lo = data;
      check("mt_hi", 64'(bus.hi), 64'(m_hi));
      check("mt_lo", 64'(bus.lo), 64'(m_lo));
      @(negedge clk);
   endtask

   task automatic invalid_start();
      logic [4:0] op;
      op = OP_MUL;
      for (int i = 0; i < 20 && (op == OP_MUL || op == OP_MULU || op == OP_DIV || op == OP_DIVU); i++)
         op = 5'($urandom);
      if (op >= OP_MUL && op <= OP_DIVU) op = 5'h00;
      bus.start = 1'b1; bus.op = op; bus.A = $urandom; bus.B = $urandom;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("invalid_op_ignored", 64'({bus.busy, bus.hi, bus.lo}), 64'({1'b0, m_hi, m_lo}));
      @(negedge clk);
   endtask

   task automatic reset_mid_op();
      bus.start = 1'b1; bus.op = OP_DIV; bus.A = $urandom; bus.B = $urandom | 32'd1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      m_hi = 32'd0; m_lo = 32'd0;
      repeat (40) @(negedge clk);
   endtask

   initial begin
      bus.start = 1'b0; bus.op = 5'd0; bus.A = 32'd0; bus.B = 32'd0;
      bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = 32'd0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      check("reset_hi", 64'(bus.hi), 64'd0);
      check("reset_lo", 64'(bus.lo), 64'd0);
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      @(negedge clk);

      mt_write(1'b0, 1'b1, 32'h1234_5678);
      mt_write(1'b1, 1'b0, 32'hCAFE_F00D);
      mt_write(1'b1, 1'b1, 32'h0BAD_BEEF);

      run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_LAT, 1'b0);
      run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 32'h0FFF_FFFF, 1'b0, DIV_LAT, 1'b0);
      run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, DIV_LAT, 1'b0);
      run_op(OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 1'b0, DIV_LAT, 1'b0);
      run_op(OP_DIV,  32'h0000_1234, 32'd0,        32'h0,         32'h0,         1'b1, 2,       1'b0);
      run_op(OP_MUL,  32'hFFFF_FFFF, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, MUL_LAT, 1'b0);
      run_op(OP_MULU, 32'hFFFF_FFFF, 32'd5,        32'h0000_0004, 32'hFFFF_FFFB, 1'b0, MUL_LAT, 1'b0);
      run_op(OP_MUL,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0, MUL_LAT, 1'b0);
      run_op(OP_DIVU, 32'd5,         32'd0,        32'h0,         32'h0,         1'b1, 2,       1'b1);
      run_op(OP_DIVU, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0, DIV_LAT, 1'b1);

      invalid_start();
      reset_mid_op();

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0: mt_write(1'($urandom), 1'($urandom), $urandom);
            1: invalid_start();
            default: rand_op();
         endcase
      end

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
